load_store_unit: RTL and testbench

Initiator side of the data-memory interface. Sits in the CPU MEM stage between the pipeline and the 256-word, word-addressed data memory. The memory has a combinational read and writes on the clock edge.
Accepts one load/store request at a time. Supports byte, halfword and word accesses, signed and unsigned. Sub-word stores are done as read-modify-write. Returns an extended load result with a one-cycle response pulse.

---
 rtl/load_store_unit.sv | 161 ++++++++++++++++
 tb/tb_load_store_unit.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store initiator for a 256-word, word-addressed data memory with combinational read.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned halfword/word accesses instead of forcing alignment.
module load_store_unit #(
  parameter int ADDR_WIDTH    = 32,
  parameter int MEM_ADDR_BITS = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic                  resp_err,
  output logic [31:0]           load_data,
  output logic                  dmem_read,
  output logic                  dmem_write,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [31:0]           dmem_wdata,
  input  logic [31:0]           dmem_rdata
);

  typedef enum logic [2:0] {IDLE, LOAD, RMW, STORE, RESP} state_t;

  state_t      state;
  logic [1:0]  lane_p0;
  logic [1:0]  size_p0;
  logic        uns_p0;
  logic [15:0] wdata_p0;
  logic        accept;
  logic        out_of_range;
  logic        misalign;
  logic        req_error;

  // Lane selection: byte uses addr[1:0], halfword addr[1], word is always lane 0.
  function automatic logic [1:0] access_lane(input logic [1:0] a, input logic [1:0] size);
    case (size)
      2'b00:   return a;
      2'b01:   return {a[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [31:0] extend_load(input logic [31:0] word, input logic [1:0] lane,
                                              input logic [1:0] size, input logic uns);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = word[{lane[1], 4'b0000} +: 16];
    case (size)
      2'b00:   return uns ? {24'h0, b} : 32'(b);
      2'b01:   return uns ? {16'h0, h} : 32'(h);
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] merge_store(input logic [31:0] word, input logic [15:0] wdata,
                                              input logic [1:0] lane, input logic [1:0] size);
    logic [31:0] m;
    m = word;
    if (size == 2'b00)
      m[{lane, 3'b000} +: 8] = wdata[7:0];
    else
      m[{lane[1], 4'b0000} +: 16] = wdata;
    return m;
  endfunction

  assign accept       = req_valid && req_ready;
  assign out_of_range = (req_addr >> MEM_ADDR_BITS) != '0;

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = ((req_size == 2'b01) && req_addr[0]) ||
                    ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign req_error = (req_size == 2'b11) || out_of_range || misalign;

  // Request capture (p0): fields needed after acceptance
  always_ff @(posedge clk) begin
    if (accept) begin
      lane_p0  <= access_lane(req_addr[1:0], req_size);
      size_p0  <= req_size;
      uns_p0   <= req_unsigned;
      wdata_p0 <= req_wdata[15:0];
    end
  end

  // Control FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      load_data  <= 32'h0;
      dmem_read  <= 1'b0;
      dmem_write <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= 32'h0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (accept) begin
            req_ready <= 1'b0;
            if (req_error) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end else begin
              resp_err  <= 1'b0;
              dmem_addr <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
              if (!req_write) begin
                state     <= LOAD;
                dmem_read <= 1'b1;
              end else if (req_size == 2'b10) begin
                state      <= STORE;
                dmem_write <= 1'b1;
                dmem_wdata <= req_wdata;
              end else begin
                state     <= RMW;
                dmem_read <= 1'b1;
              end
            end
          end
        end
        LOAD: begin
          load_data  <= extend_load(dmem_rdata, lane_p0, size_p0, uns_p0);
          dmem_read  <= 1'b0;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RMW: begin
          dmem_read  <= 1'b0;
          dmem_write <= 1'b1;
          dmem_wdata <= merge_store(dmem_rdata, wdata_p0, lane_p0, size_p0);
          state      <= STORE;
        end
        STORE: begin
          dmem_write <= 1'b0;
          dmem_wdata <= 32'h0;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          resp_err  <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed requests against a 256-word memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] load_data;
  logic        dmem_read;
  logic        dmem_write;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;

  load_store_unit #(.ADDR_WIDTH(32), .MEM_ADDR_BITS(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_err(resp_err),
    .load_data(load_data), .dmem_read(dmem_read), .dmem_write(dmem_write),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:255];
  assign dmem_rdata = dmem_read ? mem[dmem_addr[9:2]] : 32'h0;
  always @(posedge clk) if (dmem_write) mem[dmem_addr[9:2]] <= dmem_wdata;

  typedef struct {
    string       name;
    logic        err;
    logic        chk_data;
    logic [31:0] data;
    int          lat;
    int          nrd;
    int          nwr;
    logic [31:0] wdata;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  logic [31:0] last_wd = 32'h0;
  logic [31:0] last_wa = 32'h0;
  logic [31:0] exp_ld = 32'h0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: protocol rules every cycle, scoreboard pop on each response
  always @(negedge clk) begin
    if (!rst_n) begin
      rd_cnt = 0;
      wr_cnt = 0;
    end else begin
      if (dmem_read && dmem_write) chk("rd_wr_exclusive", 32'd1, 32'd0);
      if (!dmem_write && dmem_wdata != 32'h0) chk("wdata_idle_zero", dmem_wdata, 32'h0);
      if (dmem_read) rd_cnt++;
      if (dmem_write) begin
        wr_cnt++;
        last_wd = dmem_wdata;
        last_wa = dmem_addr;
      end
      if (resp_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_resp", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk({e.name, "_err"}, resp_err, e.err);
          chk({e.name, "_lat"}, cyc - e.acc, e.lat);
          chk({e.name, "_nrd"}, rd_cnt, e.nrd);
          chk({e.name, "_nwr"}, wr_cnt, e.nwr);
          if (e.chk_data) chk({e.name, "_data"}, load_data, e.data);
          if (e.nwr > 0) begin
            chk({e.name, "_wdata"}, last_wd, e.wdata);
            chk({e.name, "_waddr"}, last_wa, 32'h20);
          end
        end
        rd_cnt = 0;
        wr_cnt = 0;
      end
    end
  end

  task automatic issue(input string name, input logic wr, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd, input logic err,
                       input logic [31:0] data, input int lat, input int nrd, input int nwr,
                       input logic [31:0] wexp);
    exp_t e;
    int   n;
    @(negedge clk);
    req_write = wr; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wd;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    if (!req_ready) begin
      chk({name, "_accept_timeout"}, 32'd1, 32'd0);
      req_valid = 1'b0;
      return;
    end
    if (err) e.data = exp_ld;
    else if (!wr) begin e.data = data; exp_ld = data; end
    else e.data = 32'h0;
    e.name = name; e.err = err; e.chk_data = err || !wr; e.lat = lat;
    e.nrd = nrd; e.nwr = nwr; e.wdata = wexp; e.acc = cyc;
    sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 50) begin @(negedge clk); n++; end
    if (sb.size() != 0) begin
      chk({name, "_resp_timeout"}, 32'd1, 32'd0);
      sb.delete();
    end
  endtask

  task automatic ld(input string name, input logic [1:0] size, input logic uns,
                    input logic [31:0] addr, input logic [31:0] data);
    issue(name, 1'b0, size, uns, addr, 32'h0, 1'b0, data, 2, 1, 0, 32'h0);
  endtask

  task automatic ld_err(input string name, input logic [1:0] size, input logic [31:0] addr);
    issue(name, 1'b0, size, 1'b0, addr, 32'h0, 1'b1, 32'h0, 1, 0, 0, 32'h0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_ready", req_ready, 1'b0);
    chk("rst_outputs", {resp_valid, resp_err, dmem_read, dmem_write}, 4'b0);
    chk("rst_load_data", load_data, 32'h0);
    chk("rst_dmem_addr", dmem_addr, 32'h0);
    chk("rst_dmem_wdata", dmem_wdata, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", req_ready, 1'b1);

    issue("sw", 1'b1, 2'b10, 1'b0, 32'h20, 32'hA1B2C3F4, 1'b0, 32'h0, 2, 0, 1, 32'hA1B2C3F4);
    ld("lb",  2'b00, 1'b0, 32'h20, 32'hFFFFFFF4);
    ld("lbu", 2'b00, 1'b1, 32'h20, 32'h000000F4);
    ld("lh",  2'b01, 1'b0, 32'h22, 32'hFFFFA1B2);
    ld("lhu", 2'b01, 1'b1, 32'h22, 32'h0000A1B2);
    issue("sb", 1'b1, 2'b00, 1'b0, 32'h21, 32'h0000005A, 1'b0, 32'h0, 3, 1, 1, 32'hA1B25AF4);
    ld("lw",  2'b10, 1'b0, 32'h20, 32'hA1B25AF4);
`ifdef LSU_MISALIGN_TRAP_EN
    ld_err("lh_mis21", 2'b01, 32'h21);
    ld_err("lh_mis23", 2'b01, 32'h23);
    ld_err("lw_mis22", 2'b10, 32'h22);
`else
    ld("lh_mis21", 2'b01, 1'b0, 32'h21, 32'h00005AF4);
    ld("lh_mis23", 2'b01, 1'b0, 32'h23, 32'hFFFFA1B2);
    ld("lw_mis22", 2'b10, 1'b0, 32'h22, 32'hA1B25AF4);
`endif
    ld_err("lw_range", 2'b10, 32'h400);
    ld_err("size11", 2'b11, 32'h20);
    issue("sh_range", 1'b1, 2'b01, 1'b0, 32'h8000_0020, 32'h1234, 1'b1, 32'h0, 1, 0, 0, 32'h0);

    // Reset asserted while the sub-word store is in its read cycle
    @(negedge clk);
    req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0; req_addr = 32'h20;
    req_wdata = 32'h77; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    chk("rmw_accept", req_ready, 1'b1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("rmw_read", dmem_read, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rmw_rst_ctrl", {req_ready, resp_valid, resp_err, dmem_read, dmem_write}, 5'b0);
    chk("rmw_rst_load_data", load_data, 32'h0);
    chk("rmw_rst_addr", dmem_addr, 32'h0);
    chk("rmw_rst_wdata", dmem_wdata, 32'h0);
    exp_ld = 32'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rmw_post_ready", req_ready, 1'b1);
    ld("lw_after_rst", 2'b10, 1'b0, 32'h20, 32'hA1B25AF4);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
